// File: rtl/hier_leaf_pkg.sv
// Shared widths and the tag-insertion helper for the hierarchy leaf FIFO.
// The helper works on a fixed maximum payload width so every leaf variant shares it.
package hier_leaf_pkg;

  localparam int TAG_W      = 8;
  localparam int CNT_W      = 16;
  localparam int MAX_DATA_W = 128;

  // Places tag directly above the low data_w payload bits; callers keep data_w < MAX_DATA_W.
  function automatic logic [TAG_W+MAX_DATA_W-1:0] tag_word(
    input logic [TAG_W-1:0]      tag,
    input logic [MAX_DATA_W-1:0] payload,
    input int                    data_w
  );
    logic [TAG_W+MAX_DATA_W-1:0] tag_ext;
    tag_ext = {{MAX_DATA_W{1'b0}}, tag};
    return (tag_ext << data_w) | {{TAG_W{1'b0}}, payload};
  endfunction

endpackage

// File: rtl/hier_leaf_ptr_ctrl.sv
// Read/write pointer, occupancy and full/empty tracking for the leaf FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module hier_leaf_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push_req,
  input  logic                       pop_req,
  output logic                       push,
  output logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_idx,
  output logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0] wr_ptr;
  logic [IDX_W:0] rd_ptr;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  // Both qualifiers use registered state only, so a pop never frees space in the same cycle.
  assign push   = push_req && !full;
  assign pop    = pop_req && !empty;
  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign level  = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/hier_leaf_tag_fifo.sv
// Leaf payload: small FIFO that tags every word with a per-instance LEAF_ID
// and counts delivered words.
module hier_leaf_tag_fifo
  import hier_leaf_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int LEAF_ID = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W+TAG_W-1:0]   out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic [CNT_W-1:0]          pkt_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] TAG = LEAF_ID[TAG_W-1:0];

  // Handshake: a word moves on a rising edge where valid && ready; valid must not
  // depend on ready, and ready/valid here come from registered occupancy only.
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [IDX_W-1:0]         wr_idx;
  logic [IDX_W-1:0]         rd_idx;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DATA_W-1:0]        head;
  logic [TAG_W+MAX_DATA_W-1:0] tagged_wide;
  logic [CNT_W-1:0]         pkt_cnt_q;
  logic                     unused_hi;

  hier_leaf_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_req (in_valid),
    .pop_req  (out_ready),
    .push     (push),
    .pop      (pop),
    .wr_idx   (wr_idx),
    .rd_idx   (rd_idx),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_idx] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pkt_cnt_q <= '0;
    else if (pop && !flush)  pkt_cnt_q <= pkt_cnt_q + 1'b1;
  end

  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign head        = mem[rd_idx];
  assign tagged_wide = tag_word(TAG, {{(MAX_DATA_W-DATA_W){1'b0}}, head}, DATA_W);
  // Gating keeps out_data at zero while empty, since storage itself is never reset.
  assign out_data    = out_valid ? tagged_wide[DATA_W+TAG_W-1:0] : '0;
  assign unused_hi   = ^tagged_wide[TAG_W+MAX_DATA_W-1:DATA_W+TAG_W];
  assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_hier_leaf_tag_fifo.sv
// Directed bench for hier_leaf_tag_fifo (DATA_W=16, DEPTH=4, LEAF_ID=0x05).
module tb_hier_leaf_tag_fifo;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [2:0]  level;
  logic [15:0] pkt_cnt;

  int n_vec;
  int n_err;
  logic [23:0] exp_q[$];

  hier_leaf_tag_fifo #(.DATA_W(16), .DEPTH(4), .LEAF_ID(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .pkt_cnt   (pkt_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) tick();
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 24'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 000000", out_data); end
    n_vec++; if (pkt_cnt !== 16'h0) begin n_err++; $display("FAIL reset_pkt_cnt: got %h want 0000", pkt_cnt); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fill_three();
    logic [15:0] w [3];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = w[i];
      tick();
      if (i == 0) begin
        n_vec++; if (out_valid !== 1'b1 || out_data !== 24'h051111) begin
          n_err++; $display("FAIL first_latency: got valid=%b data=%h want 1/051111", out_valid, out_data); end
      end
    end
    in_valid = 1'b0;
    n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL fill_level: got %0d want 3", level); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_in_ready: got %b want 1", in_ready); end
    tick();
    n_vec++; if (out_data !== 24'h051111) begin n_err++; $display("FAIL fill_hold: got %h want 051111", out_data); end
  endtask

  task automatic test_full();
    in_valid = 1'b1; in_data = 16'h4444;
    tick();
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d want 4", level); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    in_data = 16'h5555;
    tick();
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL full_reject_level: got %0d want 4", level); end
    n_vec++; if (out_data !== 24'h051111) begin n_err++; $display("FAIL full_head: got %h want 051111", out_data); end
    in_valid = 1'b0;
  endtask

  task automatic test_full_pop_push();
    logic [23:0] d [3];
    in_valid = 1'b1; in_data = 16'h6666; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL fpp_level: got %0d want 3", level); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fpp_in_ready: got %b want 1", in_ready); end
    n_vec++; if (pkt_cnt !== 16'd1) begin n_err++; $display("FAIL fpp_pkt_cnt: got %0d want 1", pkt_cnt); end
    d[0] = 24'h052222; d[1] = 24'h053333; d[2] = 24'h054444;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (out_valid !== 1'b1 || out_data !== d[i]) begin
        n_err++; $display("FAIL drain_%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, d[i]); end
      tick();
    end
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || level !== 3'd0) begin
      n_err++; $display("FAIL drain_empty: got valid=%b level=%0d want 0/0", out_valid, level); end
    n_vec++; if (pkt_cnt !== 16'd4) begin n_err++; $display("FAIL drain_pkt_cnt: got %0d want 4", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    int sent;
    int got;
    int guard;
    logic do_push;
    logic do_pop;
    reset_pulse();
    exp_q.delete();
    sent = 0; got = 0; guard = 0;
    out_ready = 1'b1;
    while (got < 10 && guard < 40) begin
      in_valid = (sent < 10);
      in_data  = 16'hA000 + 16'(sent);
      do_push  = in_valid && (exp_q.size() < 4);
      do_pop   = (exp_q.size() > 0);
      if (do_pop) begin
        n_vec++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
          n_err++; $display("FAIL stream_word_%0d: got valid=%b data=%h want 1/%h", got, out_valid, out_data, exp_q[0]); end
      end
      tick();
      if (do_pop) begin void'(exp_q.pop_front()); got++; end
      if (do_push) begin exp_q.push_back({8'h05, in_data}); sent++; end
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (guard >= 40) begin n_err++; $display("FAIL stream_timeout: got %0d words want 10", got); end
    n_vec++; if (pkt_cnt !== 16'd10) begin n_err++; $display("FAIL stream_pkt_cnt: got %0d want 10", pkt_cnt); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL stream_level: got %0d want 0", level); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = 16'h7777; tick();
    in_data = 16'h8888; tick();
    in_valid = 1'b0;
    n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL flush_pre_level: got %0d want 2", level); end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h9999; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", level); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_vec++; if (pkt_cnt !== 16'd10) begin n_err++; $display("FAIL flush_pkt_cnt: got %0d want 10", pkt_cnt); end
    n_vec++; if (out_data !== 24'h0) begin n_err++; $display("FAIL flush_out_data: got %h want 000000", out_data); end
    in_valid = 1'b1; in_data = 16'hBBBB; tick();
    in_valid = 1'b0;
    n_vec++; if (out_data !== 24'h05BBBB || level !== 3'd1) begin
      n_err++; $display("FAIL post_flush_push: got data=%h level=%0d want 05BBBB/1", out_data, level); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_vec++; if (pkt_cnt !== 16'd11) begin n_err++; $display("FAIL post_flush_pop: got %0d want 11", pkt_cnt); end
  endtask

  task automatic test_cnt_wrap();
    logic [15:0] e [3];
    reset_pulse();
    in_valid = 1'b1; out_ready = 1'b1; in_data = 16'h0C0C;
    repeat (65535) tick();
    n_vec++; if (pkt_cnt !== 16'hFFFE || level !== 3'd1) begin
      n_err++; $display("FAIL wrap_preload: got cnt=%h level=%0d want FFFE/1", pkt_cnt, level); end
    out_ready = 1'b0;
    repeat (2) tick();
    in_valid = 1'b0;
    n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL wrap_level: got %0d want 3", level); end
    e[0] = 16'hFFFF; e[1] = 16'h0000; e[2] = 16'h0001;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (pkt_cnt !== e[i]) begin n_err++; $display("FAIL wrap_cnt_%0d: got %h want %h", i, pkt_cnt, e[i]); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 16'hCAFE; tick();
    in_data = 16'hBEEF; tick();
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL midrst_level: got %0d want 0", level); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 24'h0) begin n_err++; $display("FAIL midrst_out_data: got %h want 000000", out_data); end
    n_vec++; if (pkt_cnt !== 16'h0) begin n_err++; $display("FAIL midrst_pkt_cnt: got %h want 0000", pkt_cnt); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL midrst_after: got %0d want 0", level); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_fill_three();
    test_full();
    test_full_pop_push();
    test_back_to_back();
    test_flush();
    test_cnt_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hier_leaf_tag_fifo.md
Name: hier_leaf_tag_fifo

Overview:
- Leaf stage instanced at the bottom level of the generated root-module hierarchy, directly beneath the last fan-out layer.
- Gives each leaf real sequential content: accepts a valid/ready stream, buffers it in a small FIFO, and prefixes every word with a per-instance LEAF_ID tag.
- Forwards tagged words downstream and counts delivered words.
- Used as the standard leaf payload when stress-testing hierarchy elaboration and synthesis.

Parameters:
- DATA_W, 16: payload width in bits, ≥1.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- LEAF_ID, 0: 8-bit instance tag prepended to every output word.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- flush  input  1: synchronous clear of FIFO contents.
- in_valid  input  1: upstream word valid.
- in_ready  output  1: FIFO can accept a word.
- in_data  input  DATA_W: upstream payload.
- out_valid  output  1: head word available.
- out_ready  input  1: downstream accepts the head word.
- out_data  output  DATA_W+8: {LEAF_ID[7:0], payload}.
- level  output  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- pkt_cnt  output  16: count of completed output handshakes.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, read/write pointers 0, level=0, pkt_cnt=0, out_valid=0, out_data=0. in_ready=1 once rst_n deasserts.
- Push: happens when in_valid && in_ready. Pop: happens when out_valid && out_ready.
- in_ready = (level != DEPTH). It is a function of registered state only; no combinational path from out_ready.
  - When full, a same-cycle pop does NOT enable a push; the next push is accepted the following cycle.
- out_valid = (level != 0), registered state only.
- out_data is driven from the head entry; it is stable while out_valid=1 and out_ready=0.
- Latency: a word pushed into an empty FIFO appears with out_valid=1 in the next cycle. No same-cycle bypass.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both pointers advance.
- Pointers are $clog2(DEPTH)+1 bits wide, with a wrap bit.
  - full = same index, different wrap bit; empty = pointers equal.
  - Wrap-around past DEPTH-1 is transparent to the interface.
- Tag is a constant: out_data[DATA_W+7:DATA_W] = LEAF_ID[7:0]. LEAF_ID values above 255 are truncated.
- pkt_cnt increments by 1 on each pop and wraps 0xFFFF -> 0x0000. It is unaffected by flush.
- flush=1:
  - Next cycle: level=0 and out_valid=0; pointers reset to 0.
  - Flush has priority over any same-cycle push or pop. The pushed word is discarded. The pop is not counted, even though out_ready was sampled.
- Reset asserted mid-transfer: contents lost immediately and all outputs return to reset values. No partial state survives.
- Storage array is not reset. Only pointers, counters and registered outputs are reset.

Decomposition:
- Package hier_leaf_pkg:
  - TAG_W=8
  - CNT_W=16
  - function that builds the tagged word from a tag and a payload
- One natural sub-module, hier_leaf_ptr_ctrl: pointer/level/full/empty logic, parameterised by DEPTH. The top level holds the storage array, tag insertion and pkt_cnt.
- The leaf is instanced by the generated sa8-level modules with distinct LEAF_ID values 0..4.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 with out_ready=0 (LEAF_ID=0x05) -> level=3, in_ready=1, out_data=0x051111 held stable.
- Push 4 words with DEPTH=4, out_ready=0 -> in_ready=0 after the 4th accept. A 5th in_valid is not accepted; level stays 4.
- Full FIFO with out_ready=1 and in_valid=1 in the same cycle -> pop occurs, push rejected; next cycle level=3 and in_ready=1.
- Stream 10 words with in_valid=out_ready=1 continuously -> outputs in order, pointers wrap twice, pkt_cnt=10, no word lost or duplicated.
- level=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, pkt_cnt unchanged.
- Preload pkt_cnt near the limit (0xFFFE via forced state or 65534 transfers), then 3 pops -> pkt_cnt sequence 0xFFFF, 0x0000, 0x0001. Assert rst_n low mid-stream -> all outputs return to reset values immediately.
